gmii_tx_source: RTL
===================

# gmii_tx_source

MAC-side GMII frame source that drives the PCS transmit inputs (TXD, TX_EN, TX_ER) on GTX_CLK. On a start request it emits preamble, SFD, a deterministic payload and, optionally, a CRC-32 FCS, then enforces a minimum inter-frame gap. It replaces hand-written stimulus in the PCS benches with a reusable, self-checking upstream stage.

## Interface
- PREAMBLE_LEN, 7: number of 0x55 preamble bytes before the SFD (1..15).
- MIN_IFG, 12: idle cycles with TX_EN low after each frame (1..255).
- GTX_CLK  in  1  transmit clock; all state updates on the rising edge.
- mr_main_reset  in  1  reset; asynchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- frame_len  in  11  payload byte count, latched on accepted start; 0 means the start is ignored.
- seed  in  8  first payload byte, latched on accepted start.
- err_inject  in  1  when high in a DATA cycle, that byte goes out with TX_ER=1.
- TXD  out  8  GMII transmit data.
- TX_EN  out  1  GMII transmit enable.
- TX_ER  out  1  GMII transmit error.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse in the first IFG cycle.

## Operation
- Outputs are registered. Reset values: TXD=0x00, TX_EN=0, TX_ER=0, busy=0, done=0, state=IDLE.
- States: IDLE, PREAMBLE, SFD, DATA, FCS (only with FCS_EN), IFG.
- IDLE: if start=1 and frame_len!=0, latch frame_len and seed, then go to PREAMBLE. A start with frame_len=0 does nothing.
- PREAMBLE: output TXD=0x55, TX_EN=1 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: output TXD=0xD5 for one cycle, then go to DATA.
- DATA: byte i (i=0..frame_len-1) is TXD=(seed+i) mod 256, wrapping 0xFF→0x00. After the last byte go to FCS, or to IFG without FCS_EN.
- FCS: output 4 bytes, then go to IFG.
- IFG: TX_EN=0, TX_ER=0, TXD=0x00 for MIN_IFG cycles, then go to IDLE. done=1 in the first IFG cycle only.
- TX_ER is 0 in every state except DATA. err_inject outside DATA is ignored. err_inject does not alter TXD.
- start while busy=1 is ignored; there is no queueing.
- Reset mid-frame forces all outputs to their reset values immediately. No FCS or IFG is emitted for the aborted frame.

## Timing
- start sampled high at edge k in IDLE → first preamble byte on TXD/TX_EN after edge k+1.
- TX_EN high for PREAMBLE_LEN+1+frame_len cycles, plus 4 with FCS_EN.
- Back-to-back: earliest next accepted start is the IDLE cycle after the last IFG cycle. Minimum frame period = TX_EN-high cycles + MIN_IFG + 1.
- busy rises together with TX_EN and falls when the state enters IDLE.
- err_inject sampled at edge k in DATA → TX_ER=1 on the byte presented after edge k.

## Configuration
- GMII_TX_FCS_EN defined: a CRC-32 is computed over the payload bytes only.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
  - The 4 FCS bytes are appended least-significant byte first.
- Undefined: no FCS state, no CRC logic; DATA goes directly to IFG.

## Structure
- Shared package gmii_pkg holds:
  - state enum;
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5;
  - CRC32_POLY=32'hEDB88320 and CRC32_INIT=32'hFFFFFFFF.
- One sub-module, crc32_byte: combinational next-CRC from current CRC and one data byte. It is instantiated only under GMII_TX_FCS_EN and is reused by the receive-side checker.

## Test plan
- Reset then idle: with start=0 for 50 cycles, TX_EN=0, TX_ER=0, TXD=0x00, busy=0.
- frame_len=4, seed=0xFE, no FCS: TXD is 55×7, D5, FE, FF, 00, 01. TX_EN high for 12 cycles, then 12 idle cycles. done pulses once.
- GMII_TX_FCS_EN, frame_len=9, seed=0x31 ("123456789"): payload is followed by 26, 39, F4, CB (CRC 0xCBF43926).
- err_inject high during payload byte 2 of a frame_len=5 frame: TX_ER=1 on that byte only, TXD unchanged. err_inject held high during IFG has no effect.
- start held high continuously with frame_len=1: frames repeat with exactly MIN_IFG TX_EN-low cycles plus one IDLE cycle between them. start during busy is ignored. frame_len=0 never asserts TX_EN.
- mr_main_reset asserted asynchronously mid-DATA: TX_EN, TX_ER and busy go to 0 without waiting for a clock edge. After release, the next start produces a complete new frame.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit source and the CRC-32 helper:
// state encoding, framing bytes and CRC-32 constants.
package gmii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    FCS,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 step: folds one data byte (LSB first) into
// the running CRC. Shared by the transmit source and the receive-side checker.
module crc32_byte
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_source.sv
// GMII frame source: preamble, SFD, incrementing payload, optional CRC-32 FCS
// (enabled by defining GMII_TX_FCS_EN), then a minimum inter-frame gap.
module gmii_tx_source
  import gmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_IFG      = 12
) (
  input  logic        GTX_CLK,
  input  logic        mr_main_reset,
  input  logic        start,
  input  logic [10:0] frame_len,
  input  logic [7:0]  seed,
  input  logic        err_inject,
  output logic [7:0]  TXD,
  output logic        TX_EN,
  output logic        TX_ER,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic [10:0] cnt;
  logic [10:0] len_q;
  logic [7:0]  dat;

`ifdef GMII_TX_FCS_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;

  crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (dat),
    .crc_out (crc_next)
  );

  // FCS goes out complemented, least-significant byte first.
  assign fcs_word = ~crc_q >> {cnt[1:0], 3'b000};
`endif

  // Outputs are produced from the state held during the cycle, so the wire
  // lags the state register by one edge (start at k -> preamble after k+1).
  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      dat   <= '0;
      TXD   <= '0;
      TX_EN <= 1'b0;
      TX_ER <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef GMII_TX_FCS_EN
      crc_q <= CRC32_INIT;
`endif
    end else begin
      TXD   <= '0;
      TX_EN <= 1'b0;
      TX_ER <= 1'b0;
      busy  <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && frame_len != '0) begin
            len_q <= frame_len;
            dat   <= seed;
            cnt   <= '0;
            state <= PREAMBLE;
`ifdef GMII_TX_FCS_EN
            crc_q <= CRC32_INIT;
`endif
          end
        end
        PREAMBLE: begin
          TXD   <= PREAMBLE_BYTE;
          TX_EN <= 1'b1;
          if (cnt == 11'(PREAMBLE_LEN - 1)) begin
            cnt   <= '0;
            state <= SFD;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        SFD: begin
          TXD   <= SFD_BYTE;
          TX_EN <= 1'b1;
          cnt   <= '0;
          state <= DATA;
        end
        DATA: begin
          TXD   <= dat;
          TX_EN <= 1'b1;
          TX_ER <= err_inject;
          dat   <= dat + 8'd1;
`ifdef GMII_TX_FCS_EN
          crc_q <= crc_next;
`endif
          if (cnt == len_q - 11'd1) begin
            cnt <= '0;
`ifdef GMII_TX_FCS_EN
            state <= FCS;
`else
            state <= IFG;
`endif
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
`ifdef GMII_TX_FCS_EN
        FCS: begin
          TXD   <= fcs_word[7:0];
          TX_EN <= 1'b1;
          if (cnt == 11'd3) begin
            cnt   <= '0;
            state <= IFG;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
`endif
        IFG: begin
          done <= (cnt == '0);
          // busy drops on the same edge the state returns to IDLE.
          if (cnt == 11'(MIN_IFG - 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
